// File: rtl/bit_deser_pkg.sv
// Shared types for the serial-to-parallel deserializer.
// Optional parity framing is enabled with BIT_DESER_PARITY_EN.
package bit_deser_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_deser_if.sv
// Serial input / word output bundle of bit_deser.
// master drives bits and ready; slave is the deserializer.
interface bit_deser_if #(
  parameter int WIDTH = 8
);

  logic             bit_i;
  logic             bit_vld_i;
  logic             sync_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             overflow_o;
  logic             parity_err_o;

  modport master (
    output bit_i,
    output bit_vld_i,
    output sync_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  overflow_o,
    input  parity_err_o
  );

  modport slave (
    input  bit_i,
    input  bit_vld_i,
    input  sync_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output overflow_o,
    output parity_err_o
  );

endinterface

// File: rtl/bit_deser_hold.sv
// One-entry valid/ready holding register for assembled words.
// A load while full and not draining is dropped and flagged.
module bit_deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_drop_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             drop_q;
  logic             take;

  assign take = load_i && (!valid_q || ready_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= load_i && valid_q && !ready_i;
      if (take) begin
        data_q  <= load_data_i;
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign full_drop_o = drop_q;

endmodule

// File: rtl/bit_deser.sv
// Serial-to-parallel stage: shift register, bit counter, framing FSM.
// Define BIT_DESER_PARITY_EN to append an even-parity bit to each word.
module bit_deser
  import bit_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input logic       clk_i,
  input logic       rst_n_i,
  bit_deser_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_data;
  logic             load;

  // First received bit ends up at the MSB or LSB after WIDTH shifts
  assign shifted = (LSB_FIRST != 0)
                 ? {bus.bit_i, sh_q[WIDTH-1:1]}
                 : {sh_q[WIDTH-2:0], bus.bit_i};

`ifdef BIT_DESER_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_DATA;
      cnt_q   <= '0;
      sh_q    <= '0;
`ifdef BIT_DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
`ifdef BIT_DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    load    = 1'b0;
`ifdef BIT_DESER_PARITY_EN
    perr_d    = 1'b0;
    load_data = sh_q;
`else
    load_data = shifted;
`endif
    if (bus.sync_i) begin
      state_d = S_DATA;
      cnt_d   = '0;
      if (bus.bit_vld_i) begin
        sh_d  = shifted;
        cnt_d = CNT_W'(1);
      end
    end else if (bus.bit_vld_i) begin
      unique case (state_q)
        S_DATA: begin
          sh_d = shifted;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef BIT_DESER_PARITY_EN
            state_d = S_PAR;
`else
            load = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PAR: begin
          state_d = S_DATA;
`ifdef BIT_DESER_PARITY_EN
          if (^{sh_q, bus.bit_i}) perr_d = 1'b1;
          else                    load   = 1'b1;
`endif
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  bit_deser_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (load),
    .load_data_i (load_data),
    .ready_i     (bus.ready_i),
    .data_o      (bus.data_o),
    .valid_o     (bus.valid_o),
    .full_drop_o (bus.overflow_o)
  );

`ifdef BIT_DESER_PARITY_EN
  assign bus.parity_err_o = perr_q;
`else
  assign bus.parity_err_o = 1'b0;
`endif

endmodule
